// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, memory read requests, prefetch FIFO and redirect handling.
// Optional fetch-address limit check is enabled by defining FETCH_MV_CHECK_EN.
module fetch_unit #(
    parameter int                  ADDR_W   = 20,
    parameter int                  DATA_W   = 16,
    parameter int                  DEPTH    = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC = 20'h0FFFC
`ifdef FETCH_MV_CHECK_EN
    ,
    parameter logic [ADDR_W-1:0]   MEM_LIMIT = 20'hFFFFF
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              fetch_mv
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1'b1);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_d [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
    logic [ADDR_W-1:0] fifo_pc_d   [DEPTH];

    logic credit_ok_s;
    logic limit_hit_s;
    logic issue_s;
    logic accept_s;
    logic pop_s;
    logic drop_s;
    logic push_s;

`ifdef FETCH_MV_CHECK_EN
    logic fetch_mv_q, fetch_mv_d;
    assign limit_hit_s = (fetch_pc_q > MEM_LIMIT);
    assign fetch_mv    = fetch_mv_q;
`else
    assign limit_hit_s = 1'b0;
    assign fetch_mv    = 1'b0;
`endif

    // Credits cover both in-flight reads and buffered words, so the FIFO can never overflow.
    assign credit_ok_s = ((outst_q + fifo_cnt_q) < DEPTH_C);
    assign issue_s     = (state_q == FETCH) && !halt && !redirect_valid && credit_ok_s && !limit_hit_s;
    assign accept_s    = issue_s && mem_req_ready;

    assign mem_req_valid = issue_s;
    assign mem_addr      = fetch_pc_q;

    assign instr_valid = (fifo_cnt_q != {CNT_W{1'b0}});
    assign instr_data  = fifo_data_q[rd_ptr_q];
    assign instr_pc    = fifo_pc_q[rd_ptr_q];

    assign pop_s  = instr_valid && instr_ready;
    assign drop_s = mem_rsp_valid && (redirect_valid || (discard_q != {CNT_W{1'b0}}));
    assign push_s = mem_rsp_valid && !drop_s;

    // Next-state for the control FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (limit_hit_s && !redirect_valid) begin
                    state_d = FAULT;
                end else begin
                    state_d = FETCH;
                end
            end
            HALTED: begin
                if (!halt) begin
                    state_d = FETCH;
                end else begin
                    state_d = HALTED;
                end
            end
            FAULT: begin
                if (redirect_valid) begin
                    state_d = FETCH;
                end else begin
                    state_d = FAULT;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Program counters and in-flight / discard bookkeeping.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q;
        discard_d  = discard_q;

        if (accept_s && !mem_rsp_valid) begin
            outst_d = outst_q + CNT_ONE;
        end else if (!accept_s && mem_rsp_valid) begin
            outst_d = outst_q - CNT_ONE;
        end else begin
            outst_d = outst_q;
        end

        // Everything still in flight after a redirect belongs to the old path.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            discard_d  = outst_d;
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + PC_ONE;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (push_s) begin
                rsp_pc_d = rsp_pc_q + PC_ONE;
            end else begin
                rsp_pc_d = rsp_pc_q;
            end
            if (drop_s) begin
                discard_d = discard_q - CNT_ONE;
            end else begin
                discard_d = discard_q;
            end
        end
    end

    // Prefetch FIFO pointers, occupancy and storage.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        fifo_data_d = fifo_data_q;
        fifo_pc_d   = fifo_pc_q;

        if (redirect_valid) begin
            wr_ptr_d   = {PTR_W{1'b0}};
            rd_ptr_d   = {PTR_W{1'b0}};
            fifo_cnt_d = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                fifo_cnt_d = fifo_cnt_q + CNT_ONE;
            end else if (!push_s && pop_s) begin
                fifo_cnt_d = fifo_cnt_q - CNT_ONE;
            end else begin
                fifo_cnt_d = fifo_cnt_q;
            end
        end

        if (push_s) begin
            fifo_data_d[wr_ptr_q] = mem_rsp_data;
            fifo_pc_d[wr_ptr_q]   = rsp_pc_q;
        end else begin
            fifo_data_d = fifo_data_q;
            fifo_pc_d   = fifo_pc_q;
        end
    end

`ifdef FETCH_MV_CHECK_EN
    // Violation flag is set on entering FAULT and held until a redirect.
    always_comb begin
        if (redirect_valid) begin
            fetch_mv_d = 1'b0;
        end else if ((state_q == FETCH) && (state_d == FAULT)) begin
            fetch_mv_d = 1'b1;
        end else begin
            fetch_mv_d = fetch_mv_q;
        end
    end
`endif

    // All fetch-stage state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= {CNT_W{1'b0}};
            discard_q  <= {CNT_W{1'b0}};
            fifo_cnt_q <= {CNT_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_q[i] <= {DATA_W{1'b0}};
                fifo_pc_q[i]   <= {ADDR_W{1'b0}};
            end
`ifdef FETCH_MV_CHECK_EN
            fetch_mv_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            outst_q     <= outst_d;
            discard_q   <= discard_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_data_q <= fifo_data_d;
            fifo_pc_q   <= fifo_pc_d;
`ifdef FETCH_MV_CHECK_EN
            fetch_mv_q  <= fetch_mv_d;
`endif
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the CPU: owns the program counter, issues word reads to instruction memory, buffers returned 16-bit instruction words in a small prefetch FIFO, and hands them to the execute stage over a valid/ready handshake. Jumps from execute redirect the PC, flush the FIFO and discard in-flight responses. The block sits directly upstream of the CPU execute loop and replaces its inline fetch/PC-increment.

## Interface
- ADDR_W, 20, instruction word address width (memory is 2^20 words)
- DATA_W, 16, instruction word width
- DEPTH, 4, prefetch FIFO depth (power of two, ≥2)
- RESET_PC, 20'h0FFFC, PC loaded on reset
- MEM_LIMIT, 20'hFFFFF, highest legal fetch address (used only with FETCH_MV_CHECK_EN)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  word address of request
- mem_rsp_valid  in  1  read data valid; responses return in request order, ≥1 cycle after acceptance
- mem_rsp_data  in  DATA_W  read data
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  execute consumes head
- instr_data  out  DATA_W  instruction word
- instr_pc  out  ADDR_W  address the word was fetched from
- redirect_valid  in  1  jump taken
- redirect_pc  in  ADDR_W  jump target
- halt  in  1  TRAP/stall: no new requests issued
- fetch_mv  out  1  memory-violation flag (constant 0 without FETCH_MV_CHECK_EN)

## Operation
- States: BOOT, FETCH, HALTED, FAULT. Reset → BOOT; BOOT → FETCH after one cycle (no request in BOOT).
- FETCH: mem_req_valid=1 when (outstanding + fifo_count) < DEPTH, halt=0, no redirect this cycle. mem_addr = fetch PC. On accept, fetch PC += 1 modulo 2^ADDR_W (0xFFFFF → 0x00000), outstanding += 1.
- FETCH → HALTED when halt=1; HALTED → FETCH when halt=0. In HALTED, outstanding responses still land in FIFO and FIFO still drains.
- Response: if discard count > 0, drop and decrement; else push {data, pc} into FIFO, pc taken from a tag queue (or response-PC counter) incremented per accepted response. Overflow cannot occur (credit rule above).
- Consume: instr_valid&instr_ready pops head.
- Redirect (any state except FAULT, also clears FAULT if present): fetch PC and response PC := redirect_pc; FIFO emptied; discard := outstanding after this cycle's response (a response arriving in the redirect cycle is dropped); no request issued that cycle. A pop in the same cycle completes normally (execute owns that word). Redirect outranks halt for PC update; halt still blocks issue.
- Outstanding and discard counters are log2(DEPTH)+1 bits.

## Timing
- Reset values: mem_req_valid=0, mem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, fetch_mv=0, FIFO empty, counters 0, state BOOT.
- First request at cycle 1 after reset release, addr RESET_PC.
- Response accepted cycle N → instr_valid on cycle N+1 (registered FIFO write). Fetch-to-issue throughput: one request per cycle with zero-wait memory.
- mem_req_valid, mem_addr stable while valid&!ready except on redirect (request withdrawn, new address next cycle).
- Redirect at cycle N → first request to redirect_pc at N+1; instr_valid=0 from N+1 until first new word lands.
- Reset asserted mid-operation: all state to reset values immediately; pending responses after reset release are not expected (memory reset in same domain).

## Configuration
- FETCH_MV_CHECK_EN defined: before issuing, if fetch PC > MEM_LIMIT, no request is issued, state → FAULT, fetch_mv=1 (held until redirect or reset); FIFO contents and in-flight responses still delivered.
- Undefined: no limit check, FAULT unreachable, fetch_mv tied 0, PC wraps freely.

## Test plan
- Reset release, zero-wait memory returning data=addr[15:0] → requests 0x0FFFC,0x0FFFD,...; instr_data 0xFFFC then 0xFFFD with instr_pc matching; first instr_valid cycle 3.
- instr_ready=0 held → exactly DEPTH=4 requests issued, mem_req_valid drops, FIFO full; release ready → one word per cycle, no loss/duplication.
- 3 requests outstanding, memory latency 4, redirect to 0x00100 → 3 stale responses dropped, next instr_pc=0x00100.
- Redirect coincident with pop of head 0x0FFFC → pop counted, FIFO empty next cycle, request to target next cycle.
- PC at 0xFFFFE → fetches 0xFFFFE, 0xFFFFF, 0x00000 (macro undefined); with FETCH_MV_CHECK_EN and MEM_LIMIT=0xFFFFE → 0xFFFFF not issued, fetch_mv=1, cleared by redirect to 0x00010.
- halt=1 with 2 outstanding → no new requests, both words delivered; halt=0 → issue resumes at next sequential address.
